// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 2**N requesters; presents the winner as a registered
// binary index with a valid/ready handshake for a downstream one-hot decoder.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | gnt_idx is valid and held until accepted or reset
module rr_index_arbiter #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2**N-1:0]   req,
    input  logic              gnt_ready,
    output logic              gnt_valid,
    output logic [N-1:0]      gnt_idx,
    output logic              busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] last;
    logic [N-1:0] pick_base;
    logic [N-1:0] pick_idx;

    // First set bit scanning base+1 .. base+2**N with N-bit wrap; base is checked last.
    function automatic logic [N-1:0] pick(input logic [2**N-1:0] r, input logic [N-1:0] base);
        logic [N-1:0] result;
        logic [N-1:0] step;
        logic [N-1:0] idx;
        result = '0;
        for (int i = 2**N; i >= 1; i--) begin
            step = i[N-1:0];
            idx  = base + step;
            if (r[idx]) begin
                result = idx;
            end
        end
        return result;
    endfunction

    // In GRANT the only consumer of pick_idx is the handshake, which rotates from gnt_idx.
    always_comb begin
        pick_base = (state == GRANT) ? gnt_idx : last;
        pick_idx  = pick(req, pick_base);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= '1;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        last <= gnt_idx;
                        if (|req) begin
                            gnt_idx <= pick_idx;
                        end else begin
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_rr_index_arbiter;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic [7:0]   req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [N-1:0] gnt_idx;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_index_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'hFF; gnt_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, gnt_valid); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy); end
            n_checks++;
            if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx cyc=%0d got=%0d exp=0", c, gnt_idx); end
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            n_fail++; $display("FAIL first_grant got valid=%b idx=%0d exp valid=1 idx=0", gnt_valid, gnt_idx);
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL first_grant_busy got=%b exp=1", busy); end
    endtask

    task automatic test_full_rotation();
        req = 8'hFF; gnt_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(k % 8)) begin
                n_fail++;
                $display("FAIL rotation step=%0d got valid=%b idx=%0d exp valid=1 idx=%0d", k, gnt_valid, gnt_idx, k % 8);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [2:0] exp_a [4] = '{3'd2, 3'd7, 3'd2, 3'd7};
        req = 8'b1000_0100; gnt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exp_a[k]) begin
                n_fail++;
                $display("FAIL sparse step=%0d got valid=%b idx=%0d exp valid=1 idx=%0d", k, gnt_valid, gnt_idx, exp_a[k]);
            end
        end
        req = 8'b0000_0100;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
                n_fail++;
                $display("FAIL sole_regrant step=%0d got valid=%b idx=%0d exp valid=1 idx=2", k, gnt_valid, gnt_idx);
            end
        end
        req = 8'h00;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL sparse_drain got valid=%b busy=%b exp 0/0", gnt_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] req_seq [5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        req = 8'h08; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
            n_fail++; $display("FAIL bp_grant got valid=%b idx=%0d exp valid=1 idx=3", gnt_valid, gnt_idx);
        end
        for (int k = 0; k < 5; k++) begin
            req = req_seq[k];
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got valid=%b idx=%0d exp valid=1 idx=3", k, gnt_valid, gnt_idx);
            end
        end
        gnt_ready = 1'b1; req = 8'h00;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got valid=%b exp=0", gnt_valid); end
    endtask

    task automatic test_priority_after_idle();
        req = 8'h20; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
            n_fail++; $display("FAIL pri_grant5 got valid=%b idx=%0d exp valid=1 idx=5", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b1; req = 8'h00;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL pri_idle got valid=%b exp=0", gnt_valid); end
        // ready while idle must not disturb the pointer
        step();
        req = 8'b0010_0001; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            n_fail++; $display("FAIL pri_wrap got valid=%b idx=%0d exp valid=1 idx=0", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b1;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
            n_fail++; $display("FAIL pri_next got valid=%b idx=%0d exp valid=1 idx=5", gnt_valid, gnt_idx);
        end
        req = 8'h00;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL pri_drain got valid=%b exp=0", gnt_valid); end
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h40; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
            n_fail++; $display("FAIL mid_grant6 got valid=%b idx=%0d exp valid=1 idx=6", gnt_valid, gnt_idx);
        end
        reset = 1'b1; req = 8'hC0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_idx !== 3'd0) begin
            n_fail++; $display("FAIL mid_reset got valid=%b busy=%b idx=%0d exp 0/0/0", gnt_valid, busy, gnt_idx);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
            n_fail++; $display("FAIL mid_after got valid=%b idx=%0d exp valid=1 idx=6", gnt_valid, gnt_idx);
        end
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; gnt_ready = 1'b0;
        test_reset();
        test_full_rotation();
        test_sparse_wrap();
        test_backpressure();
        test_priority_after_idle();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
